// File: rtl/pid_pkg.sv
// Shared definitions for the time-multiplexed PID controller: register map,
// step sequencer states and a width-parametrised saturation helper.
package pid_pkg;

  localparam logic [2:0] REG_KP   = 3'd0;
  localparam logic [2:0] REG_KI   = 3'd1;
  localparam logic [2:0] REG_KD   = 3'd2;
  localparam logic [2:0] REG_ILIM = 3'd3;
  localparam logic [2:0] REG_CLR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_PTERM,
    S_ITERM,
    S_DTERM,
    S_SUM
  } pid_state_t;

  // Clamp x to the signed range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pid_mul_sat.sv
// Shared PID datapath: signed D_WIDTH x (D_WIDTH+1) multiply, arithmetic
// shift right by Q_BITS (floor), saturate back to D_WIDTH.
module pid_mul_sat #(
  parameter int D_WIDTH = 16,
  parameter int Q_BITS  = 13
) (
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH:0]   b,
  output logic [D_WIDTH-1:0] y
);
  import pid_pkg::*;

  localparam int P_W = 2 * D_WIDTH + 1;

  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] shifted;

  always_comb begin
    prod    = P_W'($signed(a)) * P_W'($signed(b));
    shifted = prod >>> Q_BITS;
    y       = D_WIDTH'(sat(64'(shifted), D_WIDTH));
  end

endmodule

// File: rtl/pid_multi.sv
// N_CH-channel PID controller sharing one multiply/saturate datapath; one step
// takes five cycles from accept to out_valid.
module pid_multi #(
  parameter int D_WIDTH = 16,
  parameter int Q_BITS  = 13,
  parameter int N_CH    = 4,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_enable,
  input  logic [D_WIDTH-1:0] reg_addr,
  input  logic [D_WIDTH-1:0] reg_data,
  input  logic               iterate_enable,
  input  logic [CH_W-1:0]    iterate_ch,
  input  logic [D_WIDTH-1:0] target,
  input  logic [D_WIDTH-1:0] measurement,
  output logic               ready,
  output logic [D_WIDTH-1:0] out,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch
);
  import pid_pkg::*;

  pid_state_t state;

  logic signed [D_WIDTH-1:0] kp_a    [N_CH];
  logic signed [D_WIDTH-1:0] ki_a    [N_CH];
  logic signed [D_WIDTH-1:0] kd_a    [N_CH];
  logic signed [D_WIDTH-1:0] ilim_a  [N_CH];
  logic signed [D_WIDTH-1:0] integ_a [N_CH];
  logic signed [D_WIDTH-1:0] prev_a  [N_CH];

  logic [CH_W-1:0]           ch_l;
  logic signed [D_WIDTH-1:0] kp_l, ki_l, kd_l, ilim_l, tgt_l, meas_l;
  logic signed [D_WIDTH-1:0] e_r, p_r, i_r, d_r;
  logic                      clr_pending;

  logic [2:0]                wr_sel;
  logic [CH_W-1:0]           wr_ch;
  logic                      accept;
  logic                      clr_hit;
  logic                      unused_addr_bits;
  logic signed [D_WIDTH:0]   err_diff, d_diff, i_sum, ilim_x;
  logic signed [D_WIDTH+1:0] o_sum;
  logic signed [D_WIDTH-1:0] e_next, i_next, o_next, mul_a, mul_y;
  logic signed [D_WIDTH:0]   mul_b;

  assign wr_sel           = reg_addr[2:0];
  assign wr_ch            = reg_addr[3+CH_W-1:3];
  assign unused_addr_bits = ^reg_addr;

  pid_mul_sat #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_mul (
    .a(mul_a),
    .b(mul_b),
    .y(mul_y)
  );

  always_comb begin
    accept   = iterate_enable && ready;
    clr_hit  = write_enable && (wr_sel == REG_CLR) && (wr_ch == ch_l);
    err_diff = (D_WIDTH+1)'(tgt_l) - (D_WIDTH+1)'(meas_l);
    e_next   = D_WIDTH'(sat(64'(err_diff), D_WIDTH));
    d_diff   = (D_WIDTH+1)'(e_r) - (D_WIDTH+1)'(prev_a[ch_l]);
    mul_a    = kp_l;
    mul_b    = (D_WIDTH+1)'(e_r);
    case (state)
      S_ITERM: mul_a = ki_l;
      S_DTERM: begin
        mul_a = kd_l;
        mul_b = d_diff;
      end
      default: ;
    endcase
    i_sum  = (D_WIDTH+1)'(integ_a[ch_l]) + (D_WIDTH+1)'(mul_y);
    ilim_x = (D_WIDTH+1)'(ilim_l);
    if (i_sum > ilim_x)       i_next = ilim_l;
    else if (i_sum < -ilim_x) i_next = -ilim_l;
    else                      i_next = D_WIDTH'(i_sum);
    o_sum  = (D_WIDTH+2)'(p_r) + (D_WIDTH+2)'(i_r) + (D_WIDTH+2)'(d_r);
    o_next = D_WIDTH'(sat(64'(o_sum), D_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      out         <= '0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      ch_l        <= '0;
      kp_l        <= '0;
      ki_l        <= '0;
      kd_l        <= '0;
      ilim_l      <= '0;
      tgt_l       <= '0;
      meas_l      <= '0;
      e_r         <= '0;
      p_r         <= '0;
      i_r         <= '0;
      d_r         <= '0;
      clr_pending <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        kp_a[CH_W'(i)]    <= '0;
        ki_a[CH_W'(i)]    <= '0;
        kd_a[CH_W'(i)]    <= '0;
        ilim_a[CH_W'(i)]  <= '0;
        integ_a[CH_W'(i)] <= '0;
        prev_a[CH_W'(i)]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;

      if (write_enable) begin
        case (wr_sel)
          REG_KP:   kp_a[wr_ch]   <= reg_data;
          REG_KI:   ki_a[wr_ch]   <= reg_data;
          REG_KD:   kd_a[wr_ch]   <= reg_data;
          REG_ILIM: ilim_a[wr_ch] <= reg_data;
          REG_CLR: begin
            integ_a[wr_ch] <= '0;
            prev_a[wr_ch]  <= '0;
          end
          default: ;
        endcase
      end

      // A CLR seen anywhere during the step suppresses its final state write.
      if (state != S_IDLE && clr_hit) clr_pending <= 1'b1;

      case (state)
        S_ERR: begin
          e_r   <= e_next;
          state <= S_PTERM;
        end
        S_PTERM: begin
          p_r   <= mul_y;
          state <= S_ITERM;
        end
        S_ITERM: begin
          i_r   <= i_next;
          state <= S_DTERM;
        end
        S_DTERM: begin
          d_r   <= mul_y;
          state <= S_SUM;
          ready <= 1'b1;
        end
        S_SUM: begin
          out       <= o_next;
          out_valid <= 1'b1;
          out_ch    <= ch_l;
          if (!clr_pending && !clr_hit) begin
            integ_a[ch_l] <= i_r;
            prev_a[ch_l]  <= e_r;
          end
          state <= S_IDLE;
        end
        default: ;
      endcase

      // Accepting in SUM overlaps the next step with the result cycle.
      if (accept) begin
        state       <= S_ERR;
        ready       <= 1'b0;
        clr_pending <= 1'b0;
        ch_l        <= iterate_ch;
        tgt_l       <= target;
        meas_l      <= measurement;
        kp_l        <= kp_a[iterate_ch];
        ki_l        <= ki_a[iterate_ch];
        kd_l        <= kd_a[iterate_ch];
        ilim_l      <= ilim_a[iterate_ch][D_WIDTH-1] ? '0 : ilim_a[iterate_ch];
      end
    end
  end

endmodule

// File: tb/tb_pid_multi.sv
// Self-checking bench for pid_multi against a plain-integer PID reference model.
module tb_pid_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_enable;
  logic [15:0] reg_addr;
  logic [15:0] reg_data;
  logic        iterate_enable;
  logic [1:0]  iterate_ch;
  logic [15:0] target;
  logic [15:0] measurement;
  logic        ready;
  logic [15:0] dut_out;
  logic        out_valid;
  logic [1:0]  out_ch;

  int n_tests = 0;
  int n_fail  = 0;

  longint m_kp[4], m_ki[4], m_kd[4], m_ilim[4], m_int[4], m_prev[4];

  pid_multi #(.D_WIDTH(16), .Q_BITS(13), .N_CH(4)) dut (
    .clk(clk),
    .rst(rst),
    .write_enable(write_enable),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .iterate_enable(iterate_enable),
    .iterate_ch(iterate_ch),
    .target(target),
    .measurement(measurement),
    .ready(ready),
    .out(dut_out),
    .out_valid(out_valid),
    .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_kp[i] = 0; m_ki[i] = 0; m_kd[i] = 0;
      m_ilim[i] = 0; m_int[i] = 0; m_prev[i] = 0;
    end
  endfunction

  function automatic longint model_step(input int ch, input longint tgt, input longint meas);
    longint e, p, ii, d, lim;
    e   = sat16(tgt - meas);
    p   = sat16((m_kp[ch] * e) >>> 13);
    ii  = m_int[ch] + sat16((m_ki[ch] * e) >>> 13);
    lim = (m_ilim[ch] < 0) ? 0 : m_ilim[ch];
    if (ii > lim) ii = lim;
    else if (ii < -lim) ii = -lim;
    d   = sat16((m_kd[ch] * (e - m_prev[ch])) >>> 13);
    m_int[ch]  = ii;
    m_prev[ch] = e;
    return sat16(p + ii + d);
  endfunction

  task automatic wr(input int sel, input int ch, input longint data);
    logic signed [15:0] v;
    int unsigned junk;
    v = 16'(data);
    junk = $urandom;
    write_enable = 1'b1;
    reg_addr = 16'((junk & 32'hFFE0) | (ch << 3) | sel);
    reg_data = v;
    case (sel)
      0: m_kp[ch]   = longint'(v);
      1: m_ki[ch]   = longint'(v);
      2: m_kd[ch]   = longint'(v);
      3: m_ilim[ch] = longint'(v);
      4: begin m_int[ch] = 0; m_prev[ch] = 0; end
      default: ;
    endcase
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic do_step(input int ch, input longint tgt, input longint meas, input string nm);
    longint exp_l;
    logic [15:0] exp16;
    logic [15:0] held;
    int k;
    bit seen;
    k = 0;
    while (ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept: got %b want 1", nm, ready);
    end
    exp_l = model_step(ch, tgt, meas);
    exp16 = 16'(exp_l);
    iterate_enable = 1'b1;
    iterate_ch = 2'(ch);
    target = 16'(tgt);
    measurement = 16'(meas);
    @(negedge clk);
    iterate_enable = 1'b0;
    seen = 1'b0;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        k = c;
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen || k != 5) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (seen=%b) want 5", nm, k, seen);
    end
    if (seen) begin
      n_tests++;
      if (dut_out !== exp16) begin
        n_fail++;
        $display("FAIL %s out: got %0d want %0d", nm, $signed(dut_out), $signed(exp16));
      end
      n_tests++;
      if (out_ch !== 2'(ch)) begin
        n_fail++;
        $display("FAIL %s out_ch: got %0d want %0d", nm, out_ch, ch);
      end
      held = dut_out;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || dut_out !== held) begin
        n_fail++;
        $display("FAIL %s pulse_hold: out_valid=%b out=%0d want 0 and %0d", nm, out_valid,
                 $signed(dut_out), $signed(held));
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (dut_out !== 16'd0 || out_valid !== 1'b0 || out_ch !== 2'd0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: out=%0d valid=%b ch=%0d ready=%b want 0 0 0 1",
               $signed(dut_out), out_valid, out_ch, ready);
    end
  endtask

  task automatic test_p_only();
    wr(0, 0, 8192);
    wr(1, 0, 0);
    wr(2, 0, 0);
    do_step(0, 1000, 0, "p_only");
    for (int n = 0; n < 3; n++) begin
      int t = $urandom_range(0, 20000);
      int m = $urandom_range(0, 20000);
      t = t - 10000;
      m = m - 10000;
      do_step(0, t, m, "p_only_rand");
    end
  endtask

  task automatic test_integrator();
    wr(1, 1, 4096);
    wr(3, 1, 1200);
    wr(0, 1, 0);
    wr(2, 1, 0);
    for (int n = 0; n < 4; n++) do_step(1, 1000, 0, "integ_clamp");
  endtask

  task automatic test_derivative();
    wr(2, 2, 8192);
    wr(0, 2, 0);
    wr(1, 2, 0);
    do_step(2, 100, 0, "deriv_a");
    do_step(2, 300, 0, "deriv_b");
  endtask

  task automatic test_saturation();
    wr(0, 3, 16384);
    do_step(3, 20000, 0, "sat_pos");
    do_step(3, -20000, 20000, "sat_neg");
    do_step(0, 1000, 0, "isolation_ch0");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int ch = $urandom_range(0, 3);
      int nw = $urandom_range(0, 2);
      int t, m;
      for (int w = 0; w < nw; w++) begin
        int sel = $urandom_range(0, 7);
        int wch = $urandom_range(0, 3);
        int dat = $urandom_range(0, 32767);
        dat = dat - 12000;
        wr(sel, wch, dat);
      end
      t = $urandom_range(0, 65535);
      m = $urandom_range(0, 65535);
      t = t - 32768;
      m = m - 32768;
      do_step(ch, t, m, "random");
    end
  endtask

  task automatic test_back_to_back();
    longint q[$];
    longint exp_l;
    int last_acc;
    int n_acc;
    wr(0, 2, 4096);
    wr(1, 2, 1024);
    wr(2, 2, 2048);
    wr(3, 2, 20000);
    last_acc = -1;
    n_acc = 0;
    iterate_ch = 2'd2;
    iterate_enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      int t = $urandom_range(0, 10000);
      int m = $urandom_range(0, 10000);
      if (out_valid === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_valid: got out_valid=1 want 0");
        end else begin
          exp_l = q.pop_front();
          if (dut_out !== 16'(exp_l) || out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL b2b_out: got %0d ch %0d want %0d ch 2", $signed(dut_out), out_ch, exp_l);
          end
        end
      end
      target = 16'(t - 5000);
      measurement = 16'(m - 5000);
      if (ready === 1'b1) begin
        q.push_back(model_step(2, t - 5000, m - 5000));
        if (last_acc >= 0) begin
          n_tests++;
          if (c - last_acc != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles want 5", c - last_acc);
          end
        end
        last_acc = c;
        n_acc++;
      end
      @(negedge clk);
    end
    iterate_enable = 1'b0;
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      if (out_valid === 1'b1) begin
        exp_l = q.pop_front();
        n_tests++;
        if (dut_out !== 16'(exp_l)) begin
          n_fail++;
          $display("FAIL b2b_out_drain: got %0d want %0d", $signed(dut_out), exp_l);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (n_acc != 4 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d accepts, %0d results pending; want 4 and 0", n_acc, q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_mid_step();
    wr(0, 0, 8192);
    wr(1, 0, 0);
    wr(2, 0, 0);
    fork
      do_step(0, 1000, 0, "kp_mid_inflight");
      begin
        repeat (2) @(negedge clk);
        wr(0, 0, 16384);
      end
    join
    do_step(0, 1000, 0, "kp_mid_next");
  endtask

  task automatic test_clr_mid_step();
    wr(0, 1, 0);
    wr(2, 1, 0);
    wr(1, 1, 4096);
    wr(3, 1, 30000);
    wr(4, 1, 0);
    do_step(1, 1000, 0, "clr_pre");
    fork
      do_step(1, 1000, 0, "clr_inflight");
      begin
        repeat (4) @(negedge clk);
        wr(4, 1, 0);
      end
    join
    do_step(1, 1000, 0, "clr_after");
  endtask

  task automatic test_reset_mid_step();
    bit seen_valid;
    wr(1, 1, 4096);
    wr(3, 1, 1200);
    do_step(1, 1000, 0, "rst_pre");
    iterate_ch = 2'd1;
    target = 16'd1000;
    measurement = 16'd0;
    iterate_enable = 1'b1;
    @(posedge clk);
    #1 iterate_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    n_tests++;
    if (seen_valid) begin
      n_fail++;
      $display("FAIL rst_mid_no_valid: got out_valid pulse want none");
    end
    n_tests++;
    if (ready !== 1'b1 || dut_out !== 16'd0 || out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state: ready=%b out=%0d ch=%0d want 1 0 0", ready, $signed(dut_out), out_ch);
    end
    wr(1, 1, 4096);
    wr(3, 1, 1200);
    do_step(1, 1000, 0, "rst_integ_zero");
  endtask

  initial begin
    rst = 1'b1;
    write_enable = 1'b0;
    reg_addr = '0;
    reg_data = '0;
    iterate_enable = 1'b0;
    iterate_ch = '0;
    target = '0;
    measurement = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_p_only();
    test_integrator();
    test_derivative();
    test_saturation();
    test_write_mid_step();
    test_clr_mid_step();
    test_back_to_back();
    test_random();
    test_reset_mid_step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
